// File: rtl/comp_bist.sv
// Built-in self-test engine for an N-bit magnitude comparator.
// Sweeps every {A,B} operand pair, holds each for SETTLE cycles, then samples
// the comparator flags {O1,O2,O3} against the expected {A>B, A==B, A<B}.
// Reports pass/fail, a saturating error count and the first failing vector.
module comp_bist #(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             O1,
  input  logic             O2,
  input  logic             O3,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     first_a,
  output logic [N-1:0]     first_b,
  output logic [2:0]       first_o
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [2*N-1:0]   ab_q, ab_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N-1:0]     first_a_q, first_a_d;
  logic [N-1:0]     first_b_q, first_b_d;
  logic [2:0]       first_o_q, first_o_d;
  logic             pass_q, pass_d;

  logic [N-1:0] a_cur, b_cur;
  logic [2:0]   obs, expd;
  logic         mismatch;
  logic         last_vec;

  // Expected flags from the registered operands; any inequality is a mismatch.
  always_comb begin
    a_cur = ab_q[2*N-1:N];
    b_cur = ab_q[N-1:0];
    obs   = {O1, O2, O3};
    if (a_cur > b_cur) begin
      expd = 3'b100;
    end else if (a_cur == b_cur) begin
      expd = 3'b010;
    end else begin
      expd = 3'b001;
    end
    mismatch = (obs != expd);
    last_vec = &ab_q;
  end

  // Next-state logic for the sweep controller and result registers.
  always_comb begin
    state_d   = state_q;
    ab_d      = ab_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    first_a_d = first_a_q;
    first_b_d = first_b_q;
    first_o_d = first_o_q;
    pass_d    = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ab_d      = '0;
          cnt_d     = '0;
          err_d     = '0;
          first_a_d = '0;
          first_b_d = '0;
          first_o_d = '0;
          pass_d    = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          // err_q never returns to zero within a run, so zero marks the first failure.
          if (err_q == '0) begin
            first_a_d = a_cur;
            first_b_d = b_cur;
            first_o_d = obs;
          end
        end
        if (last_vec) begin
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          ab_d    = ab_q + 1'b1;
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ab_q      <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      first_a_q <= '0;
      first_b_q <= '0;
      first_o_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ab_q      <= ab_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      first_a_q <= first_a_d;
      first_b_q <= first_b_d;
      first_o_q <= first_o_d;
      pass_q    <= pass_d;
    end
  end

  // Status decode and output mapping.
  always_comb begin
    busy      = (state_q == StWait) || (state_q == StCheck);
    done      = (state_q == StDone);
    pass      = pass_q;
    A         = ab_q[2*N-1:N];
    B         = ab_q[N-1:0];
    err_count = err_q;
    first_a   = first_a_q;
    first_b   = first_b_q;
    first_o   = first_o_q;
  end

endmodule
